dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter LATENCY, default 2, cycles from request acceptance to response; legal range 1..15.
REQ-002 Parameter DEPTH, default 256, number of 32-bit words in internal data memory; power of two.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  MEM-stage initiator presents a load/store request.
REQ-006 req_we  input  1  1 = store, 0 = load.
REQ-007 req_funct3  input  3  RV32I width/sign code.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data, right-aligned.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  one-cycle response pulse.
REQ-012 resp_rdata  output  32  load result, extended to 32 bits.
REQ-013 resp_err  output  1  request was illegal; no memory side effect.
REQ-014 mem_busy  output  1  stall to pipeline hazard logic; it plays the role of the inverse of the ex_mem_finish input of the stall unit.

Function
REQ-015 FSM states: IDLE, WAIT, RESP.
REQ-016 req_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance occurs on a rising edge with req_valid=1 and state IDLE; all req_* fields are captured then, and later changes on req_* are ignored.
REQ-018 On acceptance, the FSM SHALL go to RESP if LATENCY=1; otherwise it SHALL go to WAIT with the counter loaded to LATENCY-2.
REQ-019 In WAIT, the counter SHALL decrement each cycle; at 0 the next state SHALL be RESP.
REQ-020 RESP SHALL last exactly one cycle, then return to IDLE; resp_valid=1 only in RESP; requests are never accepted in RESP.
REQ-021 resp_valid SHALL rise exactly LATENCY cycles after the acceptance edge; minimum back-to-back spacing is LATENCY+1 cycles.
REQ-022 mem_busy SHALL equal (IDLE & req_valid) | WAIT, combinational, and SHALL be 0 in RESP so the pipeline advances in the response cycle.
REQ-023 Legal funct3 values:
  - loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU
  - stores: 000 SB, 001 SH, 010 SW
  - all other codes SHALL give resp_err=1.
REQ-024 Misalignment SHALL give resp_err=1:
  - halfword with addr[0]=1
  - word with addr[1:0]!=0
REQ-025 Out of range SHALL give resp_err=1: addr[31:2] >= DEPTH.
REQ-026 The word index is addr[log2(DEPTH)+1:2], and the byte lane is addr[1:0].
REQ-027 A legal store SHALL update only the addressed bytes, from wdata[7:0] (SB) or wdata[15:0] (SH), on the edge entering RESP.
REQ-028 A legal load SHALL read memory on the edge entering RESP:
  - LB/LH are sign-extended.
  - LBU/LHU are zero-extended.
  - resp_rdata is held until the next response.
REQ-029 On a store or an error, resp_rdata SHALL be 0 in RESP; error requests SHALL keep the same latency as legal ones.
REQ-030 A load issued after a store to the same address SHALL return the stored data (no stale read).

Reset
REQ-031 On rst_n=0, immediately:
  - state=IDLE, counter=0
  - resp_valid=0, resp_rdata=0, resp_err=0
  - req_ready=1 after release
REQ-032 Reset asserted in WAIT SHALL abort the request, with no memory write and no response pulse.
REQ-033 Memory contents SHALL NOT be reset.

Verification
REQ-034 LATENCY=2: SW addr 0x10, data 0xDEADBEEF, then LW 0x10 -> resp_valid two cycles after each acceptance; load resp_rdata=0xDEADBEEF, resp_err=0.
REQ-035 After REQ-034: LB 0x13 -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
REQ-036 SB 0x11, data 0x55, then LW 0x10 -> 0xDEAD55EF.
REQ-037 Each of the following -> resp_err=1, resp_rdata=0, memory unchanged:
  - LW 0x12
  - SH 0x13
  - funct3=011
  - LW 0x400 with DEPTH=256
REQ-038 req_valid held high continuously -> acceptances every LATENCY+1 cycles; mem_busy=0 exactly in each RESP cycle.
REQ-039 Accept SW 0x20, data 0x12345678, assert rst_n=0 during WAIT, release, then LW 0x20 -> the old value is returned (no write), and no resp_valid pulse occurs for the aborted request.

Source files
------------

// File: rtl/dmem_responder.sv
// -----------------------------------------------------------------------------
// dmem_responder
//
// Data-memory responder for the MEM stage of an RV32I pipeline. It accepts one
// load/store request at a time, waits LATENCY cycles, then emits a one-cycle
// response pulse. Illegal requests (bad funct3, misaligned, out of range) are
// answered with resp_err=1 after the same latency and have no memory effect.
//
// Parameters
//   LATENCY  cycles from acceptance edge to the response cycle (1..15)
//   DEPTH    number of 32-bit words in the internal memory (power of two)
//
// Ports
//   clk          clock, rising edge
//   rst_n        asynchronous active-low reset
//   req_valid    request present
//   req_we       1 = store, 0 = load
//   req_funct3   RV32I width/sign code
//   req_addr     byte address
//   req_wdata    store data, right-aligned
//   req_ready    high only in IDLE; a request is accepted on the next edge
//   resp_valid   one-cycle response pulse
//   resp_rdata   load result (0 for stores/errors), held until next response
//   resp_err     request was illegal, held until next response
//   mem_busy     stall request towards the pipeline hazard logic
// -----------------------------------------------------------------------------
module dmem_responder #(
    parameter int LATENCY = 2,
    parameter int DEPTH   = 256
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_busy
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Only meaningful when LATENCY >= 2; the IDLE branch never loads it otherwise.
    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 2);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  cnt, cnt_nxt;

    // Request fields captured at acceptance.
    logic        cap_we;
    logic [2:0]  cap_f3;
    logic [31:0] cap_addr;
    logic [31:0] cap_wdata;

    // Operation being executed. With LATENCY=1 the memory access happens on
    // the acceptance edge itself, so the live request is used while in IDLE.
    logic        op_we;
    logic [2:0]  op_f3;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;

    logic          accept;
    logic          enter_resp;
    logic [1:0]    lane;
    logic [AW-1:0] idx;
    logic          f3_legal;
    logic          misalign;
    logic          out_of_range;
    logic          op_err;
    logic [31:0]   rd_word;
    logic [7:0]    byte_sel;
    logic [15:0]   half_sel;
    logic [31:0]   load_val;
    logic [3:0]    wr_be;
    logic [31:0]   wr_data;

    logic [31:0] mem [DEPTH];

    // ------------------------------------------------------------------
    // FSM: next state and outputs
    // ------------------------------------------------------------------
    // NOTE: every signal driven here gets a default first so no path leaves
    // it unassigned; otherwise synthesis infers a latch.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        mem_busy   = 1'b0;
        case (state)
            IDLE: begin
                req_ready = 1'b1;
                mem_busy  = req_valid;
                if (req_valid) begin
                    if (LATENCY == 1) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            WAIT: begin
                mem_busy = 1'b1;
                if (cnt == 4'd0) state_nxt = RESP;
                else             cnt_nxt   = cnt - 4'd1;
            end
            RESP: begin
                // Pipeline advances in the response cycle, so no stall here.
                resp_valid = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && req_valid;
    assign enter_resp = (state_nxt == RESP);

    assign op_we    = (state == IDLE) ? req_we     : cap_we;
    assign op_f3    = (state == IDLE) ? req_funct3 : cap_f3;
    assign op_addr  = (state == IDLE) ? req_addr   : cap_addr;
    assign op_wdata = (state == IDLE) ? req_wdata  : cap_wdata;

    // ------------------------------------------------------------------
    // Legality decode
    // ------------------------------------------------------------------
    assign lane = op_addr[1:0];
    assign idx  = op_addr[AW+1:2];

    always_comb begin
        f3_legal = 1'b0;
        case (op_f3)
            3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
            3'b100, 3'b101:         f3_legal = !op_we;  // LBU/LHU have no store form
            default:                f3_legal = 1'b0;
        endcase
    end

    // funct3[1:0] encodes the access size for every legal code.
    assign misalign     = ((op_f3[1:0] == 2'b01) && lane[0]) ||
                          ((op_f3[1:0] == 2'b10) && (lane != 2'b00));
    assign out_of_range = (op_addr[31:2] >= 30'(DEPTH));
    assign op_err       = !f3_legal || misalign || out_of_range;

    // ------------------------------------------------------------------
    // Load data path (little-endian lanes)
    // ------------------------------------------------------------------
    assign rd_word = mem[idx];

    always_comb begin
        byte_sel = rd_word[7:0];
        case (lane)
            2'd0: byte_sel = rd_word[7:0];
            2'd1: byte_sel = rd_word[15:8];
            2'd2: byte_sel = rd_word[23:16];
            2'd3: byte_sel = rd_word[31:24];
            default: byte_sel = rd_word[7:0];
        endcase
    end

    assign half_sel = lane[1] ? rd_word[31:16] : rd_word[15:0];

    always_comb begin
        load_val = 32'd0;
        case (op_f3)
            3'b000:  load_val = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  load_val = {{16{half_sel[15]}}, half_sel};
            3'b010:  load_val = rd_word;
            3'b100:  load_val = {24'd0, byte_sel};
            3'b101:  load_val = {16'd0, half_sel};
            default: load_val = 32'd0;
        endcase
    end

    // ------------------------------------------------------------------
    // Store byte enables and lane-replicated write data
    // ------------------------------------------------------------------
    always_comb begin
        wr_be   = 4'b0000;
        wr_data = op_wdata;
        case (op_f3[1:0])
            2'b00: begin
                wr_be   = 4'b0001 << lane;
                wr_data = {4{op_wdata[7:0]}};
            end
            2'b01: begin
                wr_be   = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{op_wdata[15:0]}};
            end
            2'b10: begin
                wr_be   = 4'b1111;
                wr_data = op_wdata;
            end
            default: wr_be = 4'b0000;
        endcase
    end

    // ------------------------------------------------------------------
    // Memory array
    // ------------------------------------------------------------------
    // NOTE: the memory has no reset; clearing it would turn the RAM into a
    // large flop array, and a reset in WAIT never reaches this write because
    // the FSM returns to IDLE before entering RESP.
    always_ff @(posedge clk) begin
        if (enter_resp && op_we && !op_err) begin
            for (int b = 0; b < 4; b++) begin
                if (wr_be[b]) mem[idx][8*b +: 8] <= wr_data[8*b +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // State, capture and response registers
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= 4'd0;
            cap_we     <= 1'b0;
            cap_f3     <= 3'd0;
            cap_addr   <= 32'd0;
            cap_wdata  <= 32'd0;
            resp_rdata <= 32'd0;
            resp_err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                cap_we    <= req_we;
                cap_f3    <= req_funct3;
                cap_addr  <= req_addr;
                cap_wdata <= req_wdata;
            end
            if (enter_resp) begin
                resp_rdata <= (op_we || op_err) ? 32'd0 : load_val;
                resp_err   <= op_err;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// -----------------------------------------------------------------------------
// tb_dmem_responder
//
// Self-checking bench for dmem_responder. A byte-array shadow memory with
// plain-arithmetic legality rules supplies expected results; directed
// scenarios use literal values.
// -----------------------------------------------------------------------------
module tb_dmem_responder;

    localparam int LATENCY = 2;
    localparam int DEPTH   = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_funct3 = 3'd0;
    logic [31:0] req_addr = 32'd0;
    logic [31:0] req_wdata = 32'd0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        mem_busy;

    int checks   = 0;
    int failures = 0;

    logic [7:0] mem_b [DEPTH*4];

    typedef struct {
        int          lat;
        logic [31:0] rdata;
        logic        err;
        logic        busy_ok;
        logic        pulse_ok;
        logic        ready_ok;
        logic [31:0] exp_rdata;
        logic        exp_err;
    } txn_t;

    dmem_responder #(.LATENCY(LATENCY), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .mem_busy   (mem_busy)
    );

    always #5 clk = ~clk;

    // Reference behaviour: access size from funct3, alignment by modulo,
    // range by word count, little-endian byte shadow memory.
    function automatic void model(input logic we, input logic [2:0] f3,
                                  input logic [31:0] addr, input logic [31:0] wdata,
                                  output logic err, output logic [31:0] rdata);
        int size;
        bit legal;
        bit sgn;
        logic [31:0] v;
        legal = 1'b1;
        sgn   = 1'b0;
        size  = 4;
        case (f3)
            3'd0: begin size = 1; sgn = 1'b1; end
            3'd1: begin size = 2; sgn = 1'b1; end
            3'd2: size = 4;
            3'd4: begin size = 1; legal = !we; end
            3'd5: begin size = 2; legal = !we; end
            default: legal = 1'b0;
        endcase
        err   = !legal || ((addr % size) != 0) || ((addr >> 2) >= DEPTH);
        rdata = 32'd0;
        if (!err) begin
            if (we) begin
                for (int b = 0; b < size; b++) mem_b[addr + b] = wdata[8*b +: 8];
            end else begin
                v = 32'd0;
                for (int b = 0; b < size; b++) v = v | (32'(mem_b[addr + b]) << (8*b));
                if (sgn && v[8*size-1]) v = v | (32'hFFFF_FFFF << (8*size));
                rdata = v;
            end
        end
    endfunction

    // Drives one request, measures its response and updates the shadow model.
    task automatic do_req(input logic we, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output txn_t t);
        model(we, f3, addr, wdata, t.exp_err, t.exp_rdata);
        t.lat   = -1;
        t.rdata = 32'd0;
        t.err   = 1'b0;
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        #1;
        t.ready_ok = (req_ready === 1'b1);
        t.busy_ok  = (mem_busy === 1'b1);
        @(posedge clk);
        #1;
        // Request fields must be ignored after acceptance.
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (resp_valid === 1'b1) begin
                t.lat     = c;
                t.rdata   = resp_rdata;
                t.err     = resp_err;
                t.busy_ok = t.busy_ok && (mem_busy === 1'b0);
                break;
            end
            t.busy_ok = t.busy_ok && (mem_busy === 1'b1);
        end
        @(negedge clk);
        t.pulse_ok = (resp_valid === 1'b0) && (resp_rdata === t.rdata) && (resp_err === t.err);
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (resp_valid !== 1'b0 || resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got valid=%b rdata=%h err=%b, want 0/0/0",
                     resp_valid, resp_rdata, resp_err);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || mem_busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_release: got ready=%b busy=%b, want 1/0", req_ready, mem_busy);
        end
    endtask

    task automatic test_fill();
        txn_t t;
        int bad = 0;
        for (int w = 0; w < DEPTH; w++) begin
            do_req(1'b1, 3'd2, 32'(w * 4), $urandom, t);
            if (t.lat != LATENCY || t.err !== 1'b0 || t.rdata !== 32'd0) bad++;
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL fill: %0d of %0d stores had wrong latency/err/rdata, want 0", bad, DEPTH);
        end
    endtask

    task automatic test_basic();
        txn_t t;
        do_req(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, t);
        checks++;
        if (t.lat != LATENCY || t.err !== 1'b0 || t.rdata !== 32'd0) begin
            failures++;
            $display("FAIL sw_0x10: lat=%0d err=%b rdata=%h, want %0d/0/0", t.lat, t.err, t.rdata, LATENCY);
        end
        checks++;
        if (!t.busy_ok || !t.ready_ok || !t.pulse_ok) begin
            failures++;
            $display("FAIL sw_handshake: busy_ok=%b ready_ok=%b pulse_ok=%b, want 1/1/1",
                     t.busy_ok, t.ready_ok, t.pulse_ok);
        end
        do_req(1'b0, 3'd2, 32'h10, $urandom, t);
        checks++;
        if (t.lat != LATENCY || t.err !== 1'b0 || t.rdata !== 32'hDEAD_BEEF) begin
            failures++;
            $display("FAIL lw_0x10: lat=%0d err=%b rdata=%h, want %0d/0/deadbeef",
                     t.lat, t.err, t.rdata, LATENCY);
        end
    endtask

    task automatic test_subword();
        txn_t t;
        logic [2:0]  f3s  [4] = '{3'd0, 3'd4, 3'd1, 3'd5};
        logic [31:0] adrs [4] = '{32'h13, 32'h13, 32'h12, 32'h10};
        logic [31:0] exps [4] = '{32'hFFFF_FFDE, 32'h0000_00DE, 32'hFFFF_DEAD, 32'h0000_BEEF};
        for (int i = 0; i < 4; i++) begin
            do_req(1'b0, f3s[i], adrs[i], $urandom, t);
            checks++;
            if (t.lat != LATENCY || t.err !== 1'b0 || t.rdata !== exps[i]) begin
                failures++;
                $display("FAIL subword_load[%0d] f3=%0d addr=%h: lat=%0d err=%b rdata=%h, want %0d/0/%h",
                         i, f3s[i], adrs[i], t.lat, t.err, t.rdata, LATENCY, exps[i]);
            end
        end
        do_req(1'b1, 3'd0, 32'h11, 32'hABCD_EF55, t);
        do_req(1'b0, 3'd2, 32'h10, $urandom, t);
        checks++;
        if (t.rdata !== 32'hDEAD_55EF || t.err !== 1'b0) begin
            failures++;
            $display("FAIL sb_merge: rdata=%h err=%b, want dead55ef/0", t.rdata, t.err);
        end
    endtask

    task automatic test_errors();
        txn_t t;
        logic        wes  [5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        logic [2:0]  f3s  [5] = '{3'd2, 3'd1, 3'd3, 3'd2, 3'd4};
        logic [31:0] adrs [5] = '{32'h12, 32'h13, 32'h10, 32'h400, 32'h10};
        for (int i = 0; i < 5; i++) begin
            do_req(wes[i], f3s[i], adrs[i], 32'h1111_1111, t);
            checks++;
            if (t.lat != LATENCY || t.err !== 1'b1 || t.rdata !== 32'd0 || !t.pulse_ok) begin
                failures++;
                $display("FAIL error_req[%0d] we=%b f3=%0d addr=%h: lat=%0d err=%b rdata=%h, want %0d/1/0",
                         i, wes[i], f3s[i], adrs[i], t.lat, t.err, t.rdata, LATENCY);
            end
        end
        do_req(1'b0, 3'd2, 32'h10, $urandom, t);
        checks++;
        if (t.rdata !== 32'hDEAD_55EF) begin
            failures++;
            $display("FAIL error_no_write: rdata=%h, want dead55ef", t.rdata);
        end
    endtask

    task automatic test_random();
        txn_t t;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        for (int i = 0; i < 300; i++) begin
            we = 1'($urandom);
            f3 = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0) addr = $urandom;
            else                           addr = 32'($urandom_range(0, DEPTH*4 - 1));
            do_req(we, f3, addr, $urandom, t);
            checks++;
            if (t.lat != LATENCY || t.err !== t.exp_err || t.rdata !== t.exp_rdata) begin
                failures++;
                $display("FAIL random[%0d] we=%b f3=%0d addr=%h: lat=%0d err=%b rdata=%h, want %0d/%b/%h",
                         i, we, f3, addr, t.lat, t.err, t.rdata, LATENCY, t.exp_err, t.exp_rdata);
            end
            checks++;
            if (!t.busy_ok || !t.ready_ok || !t.pulse_ok) begin
                failures++;
                $display("FAIL random_hs[%0d]: busy_ok=%b ready_ok=%b pulse_ok=%b, want 1/1/1",
                         i, t.busy_ok, t.ready_ok, t.pulse_ok);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_err;
        logic [31:0] exp_val;
        int prev_resp = -1;
        int prev_acc  = -1;
        int n_resp    = 0;
        int bad       = 0;
        bit drained   = 1'b0;
        model(1'b0, 3'd2, 32'h10, 32'd0, exp_err, exp_val);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b0;
        req_funct3 = 3'd2;
        req_addr   = 32'h10;
        for (int c = 0; c < 30; c++) begin
            if (c > 0) @(negedge clk);
            #1;
            if (mem_busy !== !resp_valid) bad++;
            if (resp_valid === 1'b1) begin
                if (resp_rdata !== exp_val || req_ready !== 1'b0) bad++;
                if (prev_resp >= 0 && (c - prev_resp) != LATENCY + 1) bad++;
                prev_resp = c;
                n_resp++;
            end
            if (req_ready === 1'b1) begin
                if (prev_acc >= 0 && (c - prev_acc) != LATENCY + 1) bad++;
                prev_acc = c;
            end
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL back_to_back: %0d spacing/busy/data errors, want 0", bad);
        end
        checks++;
        if (n_resp < 30 / (LATENCY + 1) - 1) begin
            failures++;
            $display("FAIL back_to_back_count: %0d responses in 30 cycles, want >= %0d",
                     n_resp, 30 / (LATENCY + 1) - 1);
        end
        req_valid = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            if (req_ready === 1'b1) begin
                drained = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!drained) begin
            failures++;
            $display("FAIL back_to_back_drain: req_ready=%b after 10 cycles, want 1", req_ready);
        end
    endtask

    task automatic test_reset_abort();
        txn_t        t;
        logic        exp_err;
        logic [31:0] old_val;
        int          pulses = 0;
        model(1'b0, 3'd2, 32'h20, 32'd0, exp_err, old_val);
        @(negedge clk);
        req_valid  = 1'b1;
        req_we     = 1'b1;
        req_funct3 = 3'd2;
        req_addr   = 32'h20;
        req_wdata  = 32'h1234_5678;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        checks++;
        if (mem_busy !== 1'b1 || req_ready !== 1'b0) begin
            failures++;
            $display("FAIL abort_in_wait: busy=%b ready=%b, want 1/0", mem_busy, req_ready);
        end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1 || mem_busy !== 1'b0 ||
            resp_rdata !== 32'd0 || resp_err !== 1'b0) begin
            failures++;
            $display("FAIL abort_async: valid=%b ready=%b busy=%b rdata=%h err=%b, want 0/1/0/0/0",
                     resp_valid, req_ready, mem_busy, resp_rdata, resp_err);
        end
        repeat (2) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (resp_valid === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL abort_no_pulse: %0d response pulses, want 0", pulses);
        end
        do_req(1'b0, 3'd2, 32'h20, $urandom, t);
        checks++;
        if (t.rdata !== old_val || t.err !== 1'b0 || t.lat != LATENCY) begin
            failures++;
            $display("FAIL abort_no_write: rdata=%h err=%b lat=%0d, want %h/0/%0d",
                     t.rdata, t.err, t.lat, old_val, LATENCY);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_basic();
        test_subword();
        test_errors();
        test_random();
        test_back_to_back();
        test_reset_abort();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
